// File: rtl/risc16_mem_arbiter.sv
// Round-robin arbiter for the RISC16 single-port data RAM (CPU port A, loader port B).
// A requester may hold a bounded lock for uninterrupted multi-access sequences.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_ARB    | open arbitration, prio_q breaks ties (0 = A, 1 = B)
// ST_LOCK_A | A owns the RAM; B waits until A releases or hits LOCK_MAX
// ST_LOCK_B | B owns the RAM; A waits until B releases or hits LOCK_MAX
module risc16_mem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic          a_lock,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic          b_lock,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } state_t;

    localparam logic [7:0] LCNT_MAX = 8'(LOCK_MAX);

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    logic [7:0] lcnt_q, lcnt_d;
    logic       a_rvalid_q, b_rvalid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ARB;
            prio_q     <= 1'b0;
            lcnt_q     <= 8'd0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            lcnt_q     <= lcnt_d;
            a_rvalid_q <= a_gnt & ~a_we;
            b_rvalid_q <= b_gnt & ~b_we;
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        lcnt_d  = lcnt_q;
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_ARB: begin
                    if (a_req && (!b_req || !prio_q)) begin
                        a_gnt = 1'b1;
                        if (a_lock) begin
                            state_d = ST_LOCK_A;
                            lcnt_d  = 8'd1;
                        end else begin
                            prio_d = 1'b1;
                        end
                    end else if (b_req) begin
                        b_gnt = 1'b1;
                        if (b_lock) begin
                            state_d = ST_LOCK_B;
                            lcnt_d  = 8'd1;
                        end else begin
                            prio_d = 1'b0;
                        end
                    end
                end
                ST_LOCK_A: begin
                    // Budget exhausted: give up this cycle so B wins the next arbitration.
                    if (lcnt_q >= LCNT_MAX) begin
                        state_d = ST_ARB;
                        prio_d  = 1'b1;
                        lcnt_d  = 8'd0;
                    end else if (a_req) begin
                        a_gnt = 1'b1;
                        if (a_lock) begin
                            lcnt_d = lcnt_q + 8'd1;
                        end else begin
                            state_d = ST_ARB;
                            prio_d  = 1'b1;
                            lcnt_d  = 8'd0;
                        end
                    end else if (!a_lock) begin
                        state_d = ST_ARB;
                        prio_d  = 1'b1;
                        lcnt_d  = 8'd0;
                    end
                end
                ST_LOCK_B: begin
                    if (lcnt_q >= LCNT_MAX) begin
                        state_d = ST_ARB;
                        prio_d  = 1'b0;
                        lcnt_d  = 8'd0;
                    end else if (b_req) begin
                        b_gnt = 1'b1;
                        if (b_lock) begin
                            lcnt_d = lcnt_q + 8'd1;
                        end else begin
                            state_d = ST_ARB;
                            prio_d  = 1'b0;
                            lcnt_d  = 8'd0;
                        end
                    end else if (!b_lock) begin
                        state_d = ST_ARB;
                        prio_d  = 1'b0;
                        lcnt_d  = 8'd0;
                    end
                end
                default: begin
                    state_d = ST_ARB;
                    lcnt_d  = 8'd0;
                end
            endcase
        end
    end

    assign ram_en    = a_gnt | b_gnt;
    assign ram_we    = (a_gnt & a_we) | (b_gnt & b_we);
    assign ram_addr  = b_gnt ? b_addr  : a_addr;
    assign ram_wdata = b_gnt ? b_wdata : a_wdata;

    // Masked by rst so a read granted just before reset never reports data.
    assign a_rvalid = a_rvalid_q & ~rst;
    assign b_rvalid = b_rvalid_q & ~rst;
    assign a_rdata  = ram_rdata;
    assign b_rdata  = ram_rdata;

endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// Bench for risc16_mem_arbiter: directed vector table, hand sequences for reset and
// lock corners, then constrained-random traffic checked against an ownership model.
module tb_risc16_mem_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int LMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    logic [DW-1:0] ram_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    risc16_mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Reference model: who owns the RAM (0 none, 1 A, 2 B), how many grants it has used,
    // which side wins a tie, and the read expected back next cycle.
    int            m_owner, m_used, m_tie, m_pend;
    logic [DW-1:0] m_pend_data;
    bit            m_pend_known;
    logic [DW-1:0] ref_mem   [256];
    bit            ref_known [256];

    logic s_a_gnt, s_b_gnt, s_a_rvalid, s_b_rvalid;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int who_wins();
        int w;
        w = 0;
        if (rst) return 0;
        if (m_owner == 0) begin
            if (a_req && b_req) w = (m_tie == 1) ? 1 : 2;
            else if (a_req)     w = 1;
            else if (b_req)     w = 2;
        end else if (m_used < LMAX) begin
            if (m_owner == 1 && a_req) w = 1;
            if (m_owner == 2 && b_req) w = 2;
        end
        return w;
    endfunction

    task automatic do_cycle();
        int            w;
        logic          w_we, w_lock, o_req, o_lock;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_data;
        @(negedge clk);
        w      = who_wins();
        w_we   = (w == 2) ? b_we    : a_we;
        w_lock = (w == 2) ? b_lock  : a_lock;
        w_addr = (w == 2) ? b_addr  : a_addr;
        w_data = (w == 2) ? b_wdata : a_wdata;
        s_a_gnt = a_gnt; s_b_gnt = b_gnt; s_a_rvalid = a_rvalid; s_b_rvalid = b_rvalid;
        chk("a_gnt", 32'(a_gnt), 32'(w == 1));
        chk("b_gnt", 32'(b_gnt), 32'(w == 2));
        chk("ram_en", 32'(ram_en), 32'(w != 0));
        chk("ram_we", 32'(ram_we), 32'(w != 0 && w_we));
        if (w != 0) begin
            chk("ram_addr", 32'(ram_addr), 32'(w_addr));
            if (w_we) chk("ram_wdata", 32'(ram_wdata), 32'(w_data));
        end
        chk("a_rvalid", 32'(a_rvalid), 32'(m_pend == 1 && !rst));
        chk("b_rvalid", 32'(b_rvalid), 32'(m_pend == 2 && !rst));
        if (m_pend == 1 && !rst && m_pend_known) chk("a_rdata", 32'(a_rdata), 32'(m_pend_data));
        if (m_pend == 2 && !rst && m_pend_known) chk("b_rdata", 32'(b_rdata), 32'(m_pend_data));
        @(posedge clk);
        if (rst) begin
            m_owner = 0; m_used = 0; m_tie = 1; m_pend = 0;
        end else begin
            m_pend = 0;
            if (w != 0) begin
                if (w_we) begin
                    ref_mem[w_addr]   = w_data;
                    ref_known[w_addr] = 1;
                end else begin
                    m_pend       = w;
                    m_pend_data  = ref_mem[w_addr];
                    m_pend_known = ref_known[w_addr];
                end
            end
            o_req  = (m_owner == 2) ? b_req  : a_req;
            o_lock = (m_owner == 2) ? b_lock : a_lock;
            if (m_owner == 0) begin
                if (w != 0) begin
                    if (w_lock) begin m_owner = w; m_used = 1; end
                    else m_tie = 3 - w;
                end
            end else if (m_used >= LMAX || (w != 0 && !w_lock) || (!o_req && !o_lock)) begin
                m_tie = 3 - m_owner; m_owner = 0; m_used = 0;
            end else if (w != 0) begin
                m_used++;
            end
        end
        #1;
    endtask

    typedef struct {
        logic          a_req, a_we, a_lock;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_wdata;
        logic          b_req, b_we, b_lock;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_wdata;
        logic          exp_a, exp_b;
    } vec_t;

    vec_t vecs[$];

    task automatic drive(input vec_t v);
        a_req = v.a_req; a_we = v.a_we; a_lock = v.a_lock; a_addr = v.a_addr; a_wdata = v.a_wdata;
        b_req = v.b_req; b_we = v.b_we; b_lock = v.b_lock; b_addr = v.b_addr; b_wdata = v.b_wdata;
    endtask

    task automatic rand_a();
        a_req = ($urandom % 4) != 0; a_we = 1'($urandom); a_lock = ($urandom % 3) == 0;
        a_addr = 8'($urandom % 16); a_wdata = 16'($urandom);
    endtask

    task automatic rand_b();
        b_req = ($urandom % 4) != 0; b_we = 1'($urandom); b_lock = ($urandom % 3) == 0;
        b_addr = 8'($urandom % 16); b_wdata = 16'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_known[i] = 0;
        m_owner = 0; m_used = 0; m_tie = 1; m_pend = 0; m_pend_data = '0; m_pend_known = 0;
        rst = 1'b1;
        drive('{0,0,0,8'h0,16'h0, 0,0,0,8'h0,16'h0, 0,0});
        #1;
        repeat (3) do_cycle();
        rst = 1'b0;
        repeat (5) do_cycle();

        //         a: req we lk addr   wdata       b: req we lk addr  wdata    ga gb
        vecs.push_back('{1,1,0,8'h10,16'h1234, 0,0,0,8'h00,16'h0000, 1,0});
        vecs.push_back('{1,0,0,8'h10,16'h0000, 0,0,0,8'h00,16'h0000, 1,0});
        vecs.push_back('{1,0,0,8'h10,16'h0000, 1,1,0,8'h20,16'hbeef, 0,1});
        vecs.push_back('{1,0,0,8'h10,16'h0000, 1,0,0,8'h20,16'h0000, 1,0});
        vecs.push_back('{1,0,0,8'h11,16'h0000, 1,0,0,8'h20,16'h0000, 0,1});
        vecs.push_back('{1,1,0,8'h11,16'h5555, 1,0,1,8'h20,16'h0000, 1,0});
        vecs.push_back('{1,0,0,8'h11,16'h0000, 1,0,1,8'h20,16'h0000, 0,1});
        vecs.push_back('{1,0,0,8'h11,16'h0000, 1,0,1,8'h21,16'h0000, 0,1});
        vecs.push_back('{1,0,0,8'h11,16'h0000, 1,1,1,8'h22,16'h0abc, 0,1});
        vecs.push_back('{1,0,0,8'h11,16'h0000, 1,0,1,8'h22,16'h0000, 0,1});
        vecs.push_back('{1,0,0,8'h11,16'h0000, 1,0,1,8'h23,16'h0000, 0,0});
        vecs.push_back('{1,0,0,8'h11,16'h0000, 1,0,1,8'h23,16'h0000, 1,0});
        vecs.push_back('{1,0,0,8'h12,16'h0000, 1,0,1,8'h23,16'h0000, 0,1});
        vecs.push_back('{1,0,0,8'h12,16'h0000, 1,0,0,8'h24,16'h0000, 0,1});
        vecs.push_back('{1,0,1,8'h12,16'h0000, 1,0,0,8'h25,16'h0000, 1,0});
        vecs.push_back('{0,0,1,8'h12,16'h0000, 1,0,0,8'h25,16'h0000, 0,0});
        vecs.push_back('{1,1,0,8'h13,16'h7777, 1,0,0,8'h25,16'h0000, 1,0});
        vecs.push_back('{1,0,0,8'h13,16'h0000, 1,0,0,8'h25,16'h0000, 0,1});
        vecs.push_back('{0,0,0,8'h00,16'h0000, 0,0,0,8'h00,16'h0000, 0,0});
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            do_cycle();
            chk($sformatf("vec%0d_a_gnt", i), 32'(s_a_gnt), 32'(vecs[i].exp_a));
            chk($sformatf("vec%0d_b_gnt", i), 32'(s_b_gnt), 32'(vecs[i].exp_b));
        end

        // Reset immediately after a read grant: the read is dropped, lock and pointer reset.
        drive('{1,0,1,8'h10,16'h0, 0,0,0,8'h0,16'h0, 0,0});
        do_cycle();
        chk("rst_seq_read_gnt", 32'(s_a_gnt), 32'd1);
        rst = 1'b1; a_req = 1'b0;
        do_cycle();
        chk("rst_seq_rvalid_in_rst", 32'(s_a_rvalid), 32'd0);
        rst = 1'b0;
        do_cycle();
        chk("rst_seq_rvalid_after", 32'(s_a_rvalid), 32'd0);
        drive('{1,0,0,8'h10,16'h0, 1,0,0,8'h11,16'h0, 0,0});
        do_cycle();
        chk("rst_seq_prio_a", 32'(s_a_gnt), 32'd1);
        do_cycle();
        chk("rst_seq_then_b", 32'(s_b_gnt), 32'd1);

        rand_a(); rand_b();
        for (int c = 0; c < 3000; c++) begin
            rst = (($urandom % 150) == 0);
            do_cycle();
            if (s_a_gnt || !a_req) rand_a();
            if (s_b_gnt || !b_req) rand_b();
        end
        rst = 1'b0;
        drive('{0,0,0,8'h0,16'h0, 0,0,0,8'h0,16'h0, 0,0});
        repeat (3) do_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
